// File: rtl/rob_alloc.sv
// rob_alloc: ring-buffer ROB entry allocator, WIDTH IDs per group, in-order commit reclaim.
// Optional stats counters are enabled by defining ROB_ALLOC_STATS_EN.
module rob_alloc #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 32,
  parameter int IDX_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  output logic [WIDTH*IDX_W-1:0]   rob_entries,
  input  logic [$clog2(WIDTH):0]   commit_cnt,
  input  logic                     flush,
  output logic [IDX_W-1:0]         head_idx,
  output logic [IDX_W:0]           count,
  output logic                     empty,
  output logic                     full,
  output logic                     commit_err,
  output logic [15:0]              stall_cycles,
  output logic [IDX_W:0]           high_water
);
  logic [IDX_W-1:0] tail, head;
  logic [IDX_W:0]   commit_ext, commit_eff, count_next;
  logic             alloc_fire, commit_over;
  assign alloc_ready = ~flush & (((IDX_W+1)'(DEPTH) - count) >= (IDX_W+1)'(WIDTH));
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign commit_ext  = (IDX_W+1)'(commit_cnt);
  assign commit_over = commit_ext > count;
  assign commit_eff  = commit_over ? count : commit_ext;
  assign count_next  = flush ? '0 : count + (alloc_fire ? (IDX_W+1)'(WIDTH) : '0) - commit_eff;
  assign head_idx    = head;
  assign empty       = count == '0;
  assign full        = count == (IDX_W+1)'(DEPTH);
  for (genvar i = 0; i < WIDTH; i++) begin : g_slot
    assign rob_entries[IDX_W*i +: IDX_W] = tail + IDX_W'(i);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tail       <= '0;
      head       <= '0;
      count      <= '0;
      commit_err <= 1'b0;
    end else begin
      tail       <= alloc_fire ? tail + IDX_W'(WIDTH) : tail;
      head       <= flush ? tail : head + commit_eff[IDX_W-1:0];
      count      <= count_next;
      commit_err <= commit_err | (~flush & commit_over);
    end
  end
`ifdef ROB_ALLOC_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      high_water   <= '0;
    end else begin
      stall_cycles <= (alloc_valid & ~alloc_ready & ~&stall_cycles) ? stall_cycles + 16'd1 : stall_cycles;
      high_water   <= count_next > high_water ? count_next : high_water;
    end
  end
`else
  assign stall_cycles = '0;
  assign high_water   = '0;
`endif
endmodule

// File: tb/tb_rob_alloc.sv
// tb_rob_alloc: directed scenarios plus random traffic checked against a queue-of-IDs model.
module tb_rob_alloc;
  logic        clk = 0, rst = 1, alloc_valid = 0, flush = 0;
  logic [2:0]  commit_cnt = 0;
  logic        alloc_ready, empty, full, commit_err;
  logic [19:0] rob_entries;
  logic [4:0]  head_idx;
  logic [5:0]  count, high_water;
  logic [15:0] stall_cycles;
  int checks = 0, errors = 0;
  int q[$];
  int next_id = 0, m_err = 0, m_stall = 0, m_hw = 0;

  rob_alloc dut (
    .clk(clk), .rst(rst), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .rob_entries(rob_entries), .commit_cnt(commit_cnt), .flush(flush),
    .head_idx(head_idx), .count(count), .empty(empty), .full(full),
    .commit_err(commit_err), .stall_cycles(stall_cycles), .high_water(high_water)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] exp_entries();
    logic [19:0] e;
    for (int i = 0; i < 4; i++) e[5*i +: 5] = 5'((next_id + i) % 32);
    return e;
  endfunction

  function automatic bit m_ready();
    return !flush && (32 - q.size() >= 4);
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".count"}, count, q.size());
    chk({tag, ".head"}, head_idx, q.size() > 0 ? q[0] : next_id);
    chk({tag, ".empty"}, empty, q.size() == 0);
    chk({tag, ".full"}, full, q.size() == 32);
    chk({tag, ".err"}, commit_err, m_err);
`ifdef ROB_ALLOC_STATS_EN
    chk({tag, ".stall"}, stall_cycles, m_stall);
    chk({tag, ".hw"}, high_water, m_hw);
`else
    chk({tag, ".stall"}, stall_cycles, 0);
    chk({tag, ".hw"}, high_water, 0);
`endif
  endtask

  task automatic step(input string tag, input bit v, input int c, input bit f);
    bit rdy;
    int eff;
    alloc_valid = v;
    commit_cnt = 3'(c);
    flush = f;
    #1;
    rdy = m_ready();
    chk({tag, ".ready"}, alloc_ready, rdy);
    chk({tag, ".entries"}, rob_entries, exp_entries());
    @(posedge clk);
    if (v && !rdy && m_stall < 16'hFFFF) m_stall++;
    if (f) q.delete();
    else begin
      if (c > q.size()) m_err = 1;
      eff = c < q.size() ? c : q.size();
      repeat (eff) void'(q.pop_front());
      if (v && rdy) begin
        for (int i = 0; i < 4; i++) q.push_back((next_id + i) % 32);
        next_id = (next_id + 4) % 32;
      end
    end
    if (q.size() > m_hw) m_hw = q.size();
    #1;
    check_state(tag);
  endtask

  initial begin
    #12 rst = 0;
    @(posedge clk);
    #1;
    chk("rst.ready", alloc_ready, 1);
    chk("rst.entries", rob_entries, 20'h18820);
    check_state("rst");
    repeat (8) step("fill", 1, 0, 0);
    chk("fill.full", full, 1);
    repeat (3) step("stall", 1, 0, 0);
    step("commit4", 0, 4, 0);
    chk("wrap.head", head_idx, 4);
    step("wrap", 0, 0, 0);
    chk("wrap.entries", rob_entries, 20'h18820);
    repeat (5) step("drain", 0, 4, 0);
    chk("drain.count", count, 8);
    step("fire_commit", 1, 2, 0);
    chk("fire_commit.count", count, 10);
    step("to12", 1, 2, 0);
    step("flush", 1, 3, 1);
    chk("flush.empty", empty, 1);
    step("e1", 1, 0, 0);
    step("e2", 0, 2, 0);
    step("over", 0, 4, 0);
    chk("over.err", commit_err, 1);
    step("hold", 1, 1, 0);
    repeat (400) begin
      bit f;
      f = ($urandom_range(0, 15) == 0);
      step("rand", 1'($urandom), f ? 0 : int'($urandom_range(0, 4)), f);
    end
    alloc_valid = 0; commit_cnt = 0; flush = 0;
    rst = 1;
    #1;
    q.delete(); next_id = 0; m_err = 0; m_stall = 0; m_hw = 0;
    check_state("async_rst");
    chk("async_rst.entries", rob_entries, 20'h18820);
    #1 rst = 0;
    @(posedge clk);
    #1;
    repeat (50) step("post", 1'($urandom), int'($urandom_range(0, 4)), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
